// File: rtl/ps2_key_event_ctrl.sv
// Decodes the PS/2 scancode byte stream (E0 extended / F0 break prefixes) into key events held
// in a first-word fall-through FIFO. Define PS2_TYPEMATIC_FILTER_EN to drop auto-repeat makes.
module ps2_key_event_ctrl #(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       valid_scan_code,
   input  logic [7:0] scan_code,
   input  logic       evt_ready,
   output logic       evt_valid,
   output logic [7:0] evt_code,
   output logic       evt_ext,
   output logic       evt_break,
   output logic       timeout,
   output logic       overflow,
   output logic       err_code
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
   } key_evt_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXT,
      S_BRK,
      S_EXT_BRK
   } state_t;

   state_t           state_q, state_d;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             vsc_prev_q, vsc_prev_d;
   logic             timeout_q, timeout_d;
   logic             err_code_q, err_code_d;
   logic             overflow_q, overflow_d;
   logic             evt_valid_q, evt_valid_d;
   key_evt_t         head_q, head_d;
   key_evt_t         mem_q [FIFO_DEPTH];
   key_evt_t         mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0] occ_q, occ_d;

   logic             strobe_c;
   logic             in_ext_c;
   logic             in_brk_c;
   logic             dec_vld_c;
   key_evt_t         dec_evt_c;
   logic             push_c;
   logic             pop_c;
   logic             full_c;
   logic             wr_en_c;

   // Prefix sequencer: next state, decoded event, timeout and error pulses
   always_comb begin
      state_d    = state_q;
      tmo_cnt_d  = tmo_cnt_q;
      timeout_d  = 1'b0;
      err_code_d = 1'b0;
      dec_vld_c  = 1'b0;
      dec_evt_c  = '0;
      in_ext_c   = 1'b0;
      in_brk_c   = 1'b0;
      vsc_prev_d = valid_scan_code;
      strobe_c   = valid_scan_code & ~vsc_prev_q;

      case (state_q)
         S_EXT:     in_ext_c = 1'b1;
         S_BRK:     in_brk_c = 1'b1;
         S_EXT_BRK: begin
            in_ext_c = 1'b1;
            in_brk_c = 1'b1;
         end
         default:   ;
      endcase

      if (strobe_c) begin
         tmo_cnt_d = '0;
         if (scan_code == 8'h00 || scan_code == 8'hFF) begin
            err_code_d = 1'b1;
            state_d    = S_IDLE;
         end else if (scan_code == 8'hE0) begin
            // E0 always restarts an extended sequence, discarding any pending break
            state_d = S_EXT;
         end else if (scan_code == 8'hF0) begin
            state_d = in_ext_c ? S_EXT_BRK : S_BRK;
         end else begin
            dec_vld_c      = 1'b1;
            dec_evt_c.code = scan_code;
            dec_evt_c.ext  = in_ext_c;
            dec_evt_c.brk  = in_brk_c;
            state_d        = S_IDLE;
         end
      end else if (state_q != S_IDLE) begin
         if (tmo_cnt_q == TMO_LAST) begin
            state_d   = S_IDLE;
            tmo_cnt_d = '0;
            timeout_d = 1'b1;
         end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
         end
      end
   end

`ifdef PS2_TYPEMATIC_FILTER_EN
   typedef struct packed {
      logic       vld;
      logic       ext;
      logic [7:0] code;
   } held_t;

   held_t held_q, held_d;
   logic  held_match_c;

   // Auto-repeat filter: a make of the currently held key is swallowed
   always_comb begin
      held_d       = held_q;
      push_c       = dec_vld_c;
      held_match_c = held_q.vld && (held_q.ext == dec_evt_c.ext) &&
                     (held_q.code == dec_evt_c.code);
      if (dec_vld_c) begin
         if (!dec_evt_c.brk) begin
            if (held_match_c) begin
               push_c = 1'b0;
            end else begin
               held_d.vld  = 1'b1;
               held_d.ext  = dec_evt_c.ext;
               held_d.code = dec_evt_c.code;
            end
         end else if (held_match_c) begin
            held_d.vld = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         held_q <= '0;
      end else begin
         held_q <= held_d;
      end
   end
`else
   assign push_c = dec_vld_c;
`endif

   // Event FIFO; head fields are registered from the post-update memory view
   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q;
      full_c     = (occ_q == OCC_FULL);
      pop_c      = evt_valid_q & evt_ready;
      wr_en_c    = push_c & (~full_c | pop_c);
      overflow_d = push_c & full_c & ~pop_c;

      if (wr_en_c) begin
         mem_d[wr_ptr_q] = dec_evt_c;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (wr_en_c && !pop_c) begin
         occ_d = occ_q + OCC_W'(1);
      end else if (!wr_en_c && pop_c) begin
         occ_d = occ_q - OCC_W'(1);
      end

      evt_valid_d = (occ_d != '0);
      head_d      = evt_valid_d ? mem_d[rd_ptr_d] : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         tmo_cnt_q   <= '0;
         vsc_prev_q  <= 1'b0;
         timeout_q   <= 1'b0;
         err_code_q  <= 1'b0;
         overflow_q  <= 1'b0;
         evt_valid_q <= 1'b0;
         head_q      <= '0;
         mem_q       <= '{default: '0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         occ_q       <= '0;
      end else begin
         state_q     <= state_d;
         tmo_cnt_q   <= tmo_cnt_d;
         vsc_prev_q  <= vsc_prev_d;
         timeout_q   <= timeout_d;
         err_code_q  <= err_code_d;
         overflow_q  <= overflow_d;
         evt_valid_q <= evt_valid_d;
         head_q      <= head_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         occ_q       <= occ_d;
      end
   end

   assign evt_valid = evt_valid_q;
   assign evt_code  = head_q.code;
   assign evt_ext   = head_q.ext;
   assign evt_break = head_q.brk;
   assign timeout   = timeout_q;
   assign overflow  = overflow_q;
   assign err_code  = err_code_q;

endmodule
